// File: rtl/free_slot_allocator.sv
// Free-slot bitmap allocator: offers the lowest NUM_ALLOC free indices each cycle, accepts NUM_FREE releases.
// Optional protocol checking (OUT_protoErr, illegal-op dropping) under `FREE_SLOT_ALLOC_CHECK_EN`.

module free_slot_priority_encoder #(
    parameter int BITS = 32,
    parameter int N    = 2,
    parameter int W    = 5
) (
    input  logic [BITS-1:0]     bits,
    output logic [N-1:0][W-1:0] idx,
    output logic [N-1:0]        valid
);
    logic [BITS-1:0] rem;

    // Peel off the lowest set bit N times; unfound ports stay at idx 0, invalid.
    always_comb begin
        rem   = bits;
        idx   = '0;
        valid = '0;
        for (int n = 0; n < N; n++) begin
            for (int b = BITS - 1; b >= 0; b--) begin
                if (rem[b]) begin
                    idx[n]   = W'(b);
                    valid[n] = 1'b1;
                end
            end
            if (valid[n]) rem[idx[n]] = 1'b0;
        end
    end
endmodule

module free_slot_allocator #(
    parameter int  SIZE      = 32,
    parameter int  NUM_ALLOC = 2,
    parameter int  NUM_FREE  = 2,
    localparam int IDX_W     = $clog2(SIZE),
    localparam int CNT_W     = $clog2(SIZE + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                IN_flush,
    input  logic [NUM_ALLOC-1:0]                IN_allocReq,
    output logic [NUM_ALLOC-1:0][IDX_W-1:0]     OUT_allocIdx,
    output logic [NUM_ALLOC-1:0]                OUT_allocValid,
    input  logic [NUM_FREE-1:0]                 IN_freeValid,
    input  logic [NUM_FREE-1:0][IDX_W-1:0]      IN_freeIdx,
    output logic [CNT_W-1:0]                    OUT_freeCount
`ifdef FREE_SLOT_ALLOC_CHECK_EN
    ,
    output logic                                OUT_protoErr
`endif
);
    logic [SIZE-1:0]                    free_q, free_n, alloc_mask, free_mask;
    logic [NUM_ALLOC-1:0]               take;
    logic [NUM_FREE-1:0]                rel_ok;
    logic                               warm_q;
    logic [NUM_ALLOC-1:0][IDX_W-1:0]    pe_idx;
    logic [NUM_ALLOC-1:0]               pe_vld;
    logic [CNT_W-1:0]                   cnt_n;

`ifdef FREE_SLOT_ALLOC_CHECK_EN
    logic err_n, err_q, pre, dup;

    // A port takes its offer only if valid and every lower port took too.
    always_comb begin
        take   = '0;
        rel_ok = '0;
        err_n  = 1'b0;
        pre    = 1'b1;
        dup    = 1'b0;
        for (int i = 0; i < NUM_ALLOC; i++) begin
            take[i] = IN_allocReq[i] & OUT_allocValid[i] & pre;
            pre     = take[i];
            if (IN_allocReq[i] && !take[i]) err_n = 1'b1;
        end
        for (int k = 0; k < NUM_FREE; k++) begin
            dup = 1'b0;
            for (int j = 0; j < k; j++)
                if (IN_freeValid[j] && IN_freeIdx[j] == IN_freeIdx[k]) dup = 1'b1;
            if (IN_freeValid[k]) begin
                if (int'(IN_freeIdx[k]) >= SIZE || dup || free_q[IN_freeIdx[k]])
                    err_n = 1'b1;
                else
                    rel_ok[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | err_n;
    end

    assign OUT_protoErr = err_q;
`else
    always_comb begin
        take   = IN_allocReq;
        rel_ok = IN_freeValid;
    end
`endif

    always_comb begin
        alloc_mask = '0;
        free_mask  = '0;
        for (int i = 0; i < NUM_ALLOC; i++)
            if (take[i]) alloc_mask[OUT_allocIdx[i]] = 1'b1;
        for (int k = 0; k < NUM_FREE; k++)
            if (rel_ok[k]) free_mask[IN_freeIdx[k]] = 1'b1;
        free_n = IN_flush ? '1 : ((free_q & ~alloc_mask) | free_mask);
    end

    always_comb begin
        cnt_n = '0;
        for (int b = 0; b < SIZE; b++) cnt_n = cnt_n + CNT_W'(free_n[b]);
    end

    free_slot_priority_encoder #(.BITS(SIZE), .N(NUM_ALLOC), .W(IDX_W)) u_pe (
        .bits  (free_n),
        .idx   (pe_idx),
        .valid (pe_vld)
    );

    // Offers are computed from the next-state bitmap so back-to-back grants need no bubble;
    // warm_q holds them off for the first cycle out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            free_q         <= '1;
            warm_q         <= 1'b0;
            OUT_allocIdx   <= '0;
            OUT_allocValid <= '0;
            OUT_freeCount  <= CNT_W'(SIZE);
        end else begin
            free_q        <= free_n;
            warm_q        <= 1'b1;
            OUT_freeCount <= cnt_n;
            if (warm_q) begin
                OUT_allocIdx   <= pe_idx;
                OUT_allocValid <= pe_vld;
            end
        end
    end
endmodule
